// File: rtl/microP_defs_pkg.sv
// Shared microprocessor definitions: address width, reset vector and
// the encodings of the next-PC sequencer states.
package microP_defs;

  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 8'h00;
  localparam int STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsmState_t;

endpackage

// File: rtl/next_pc_unit_ret_stack.sv
// Return-address LIFO. Only the pointer is reset; the entries are left
// as they are because an empty pointer makes them unreachable.
module ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   ptr;
  logic [IDX_W-1:0] topIdx;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full   = (ptr == (IDX_W+1)'(DEPTH));
  assign empty  = (ptr == '0);
  assign topIdx = ptr[IDX_W-1:0] - IDX_W'(1);
  assign top    = mem[topIdx];

  // The pointer counts entries 0..DEPTH; a push on full or a pop on empty is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + (IDX_W+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[IDX_W-1:0]] <= pushData;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC producer: boot/run/halt sequencer, control priority mux,
// address adders and a return-address stack feeding the pc block.
module next_pc_unit #(
  parameter int ADDR_W = microP_defs::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = microP_defs::RESET_VECTOR,
  parameter int STACK_DEPTH = microP_defs::STACK_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] next_pc,
  output logic              valid,
  output logic              halted,
  output logic              stk_ovf,
  output logic              stk_unf
);

  import microP_defs::*;

  fsmState_t         state;
  fsmState_t         stateNext;
  logic              update;
  logic [ADDR_W-1:0] pcInc;
  logic [ADDR_W-1:0] nextAddr;
  logic [ADDR_W-1:0] stackTop;
  logic              stackFull;
  logic              stackEmpty;
  logic              doPush;
  logic              doPop;
  logic              setOvf;
  logic              setUnf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= stateNext;
    end
  end

  // A stalled halt request is discarded like any other control.
  always_comb begin
    stateNext = state;
    unique case (state)
      BOOT:    stateNext = RUN;
      RUN:     if (!stall && halt_req) stateNext = HALT;
      HALT:    stateNext = HALT;
      default: stateNext = BOOT;
    endcase
  end

  always_comb begin
    valid  = (state == RUN);
    halted = (state == HALT);
  end

  assign update = (state == RUN) && !stall && !halt_req;
  assign pcInc  = pc_in + ADDR_W'(1);

  // Priority ret > call > jump > branch > sequential; halt already excluded by update.
  always_comb begin
    nextAddr = pcInc;
    doPush   = 1'b0;
    doPop    = 1'b0;
    setOvf   = 1'b0;
    setUnf   = 1'b0;
    if (ret) begin
      if (stackEmpty) begin
        setUnf = update;
      end else begin
        nextAddr = stackTop;
        doPop    = update;
      end
    end else if (call) begin
      nextAddr = target;
      if (stackFull) begin
        setOvf = update;
      end else begin
        doPush = update;
      end
    end else if (jump) begin
      nextAddr = target;
    end else if (branch_taken) begin
      nextAddr = pc_in + branch_off;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_pc <= RESET_VECTOR;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      if (update) next_pc <= nextAddr;
      if (setOvf) stk_ovf <= 1'b1;
      if (setUnf) stk_unf <= 1'b1;
    end
  end

  ret_stack #(
    .WIDTH(ADDR_W),
    .DEPTH(STACK_DEPTH)
  ) uRetStack (
    .clk     (clk),
    .reset   (reset),
    .push    (doPush),
    .pop     (doPop),
    .pushData(pcInc),
    .top     (stackTop),
    .full    (stackFull),
    .empty   (stackEmpty)
  );

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed test-plan scenarios then
// randomized traffic, compared against a queue-based reference model.
module tb_next_pc_unit;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pcIn = '0;
  logic          stall = 1'b0;
  logic          branchTaken = 1'b0;
  logic [AW-1:0] branchOff = '0;
  logic          jump = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic [AW-1:0] target = '0;
  logic          haltReq = 1'b0;
  logic [AW-1:0] nextPc;
  logic          valid;
  logic          halted;
  logic          stkOvf;
  logic          stkUnf;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase 0 boot, 1 run, 2 halt.
  int            mPhase;
  logic [AW-1:0] mNextPc;
  logic          mOvf;
  logic          mUnf;
  logic [AW-1:0] mStack[$];

  always #5 clk = ~clk;

  next_pc_unit #(
    .ADDR_W(AW),
    .RESET_VECTOR(8'h00),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pcIn),
    .stall       (stall),
    .branch_taken(branchTaken),
    .branch_off  (branchOff),
    .jump        (jump),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .halt_req    (haltReq),
    .next_pc     (nextPc),
    .valid       (valid),
    .halted      (halted),
    .stk_ovf     (stkOvf),
    .stk_unf     (stkUnf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".nextPc"}, 32'(nextPc), 32'(mNextPc));
    checkOutput({tag, ".valid"},  32'(valid),  32'(mPhase == 1));
    checkOutput({tag, ".halted"}, 32'(halted), 32'(mPhase == 2));
    checkOutput({tag, ".ovf"},    32'(stkOvf), 32'(mOvf));
    checkOutput({tag, ".unf"},    32'(stkUnf), 32'(mUnf));
  endtask

  task automatic modelReset();
    mPhase  = 0;
    mNextPc = 8'h00;
    mOvf    = 1'b0;
    mUnf    = 1'b0;
    mStack.delete();
  endtask

  task automatic modelEdge();
    if (mPhase == 0) begin
      mPhase = 1;
    end else if (mPhase == 1 && !stall) begin
      if (haltReq) begin
        mPhase = 2;
      end else if (ret) begin
        if (mStack.size() > 0) begin
          mNextPc = mStack.pop_back();
        end else begin
          mNextPc = pcIn + 8'd1;
          mUnf = 1'b1;
        end
      end else if (call) begin
        mNextPc = target;
        if (mStack.size() < DEPTH) mStack.push_back(pcIn + 8'd1);
        else mOvf = 1'b1;
      end else if (jump) begin
        mNextPc = target;
      end else if (branchTaken) begin
        mNextPc = pcIn + branchOff;
      end else begin
        mNextPc = pcIn + 8'd1;
      end
    end
  endtask

  task automatic applyStimulus(input logic st, input logic hr, input logic rt, input logic cl,
                               input logic jp, input logic br, input logic [AW-1:0] pc,
                               input logic [AW-1:0] off, input logic [AW-1:0] tgt);
    stall = st; haltReq = hr; ret = rt; call = cl; jump = jp; branchTaken = br;
    pcIn = pc; branchOff = off; target = tgt;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #2;
    modelReset();
    checkAll("reset");
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    doReset();

    applyStimulus(0, 0, 0, 0, 0, 0, mNextPc, 8'h00, 8'h00);
    checkAll("boot");
    checkOutput("boot.valid", 32'(valid), 32'd1);
    checkOutput("boot.pc", 32'(nextPc), 32'h00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, mNextPc, 8'h00, 8'h00);
      checkAll("seq");
      checkOutput("seqLoop", 32'(nextPc), 32'(i + 1));
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 8'hFF, 8'h00, 8'h00);
    checkOutput("wrap", 32'(nextPc), 32'h00);
    applyStimulus(0, 0, 0, 0, 0, 1, 8'h10, 8'hFC, 8'h00);
    checkOutput("branch", 32'(nextPc), 32'h0C);
    applyStimulus(0, 0, 0, 0, 1, 0, 8'h10, 8'h00, 8'h55);
    checkOutput("jump", 32'(nextPc), 32'h55);
    applyStimulus(0, 0, 0, 0, 1, 1, 8'h10, 8'hFC, 8'h55);
    checkOutput("jumpOverBranch", 32'(nextPc), 32'h55);

    applyStimulus(0, 0, 0, 1, 0, 0, 8'h20, 8'h00, 8'h80);
    checkOutput("call1", 32'(nextPc), 32'h80);
    applyStimulus(0, 0, 0, 1, 0, 0, 8'h40, 8'h00, 8'h80);
    checkOutput("call2", 32'(nextPc), 32'h80);
    applyStimulus(0, 0, 1, 0, 0, 0, 8'h80, 8'h00, 8'h00);
    checkOutput("ret1", 32'(nextPc), 32'h41);
    applyStimulus(0, 0, 1, 0, 0, 0, 8'h41, 8'h00, 8'h00);
    checkOutput("ret2", 32'(nextPc), 32'h21);
    checkAll("nest");

    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 8'(8'h10 + i), 8'h00, 8'h90);
      checkAll("callDeep");
      checkOutput("ovfFlag", 32'(stkOvf), 32'(i == 4));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 8'hA0, 8'h00, 8'h00);
      checkOutput("retLifo", 32'(nextPc), 32'(8'h14 - i));
    end
    applyStimulus(0, 0, 1, 1, 0, 0, 8'hA0, 8'h00, 8'h77);
    checkOutput("retEmpty", 32'(nextPc), 32'hA1);
    checkOutput("unfFlag", 32'(stkUnf), 32'd1);
    checkAll("flags");

    applyStimulus(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h33);
    checkOutput("stallHold", 32'(nextPc), 32'hA1);
    checkOutput("stallValid", 32'(valid), 32'd1);
    applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    checkAll("stallHalt");
    applyStimulus(0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h33);
    checkOutput("halted", 32'(halted), 32'd1);
    checkOutput("haltValid", 32'(valid), 32'd0);
    checkOutput("haltFrozen", 32'(nextPc), 32'hA1);
    applyStimulus(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h33);
    applyStimulus(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    checkAll("haltIgnore");
    checkOutput("haltSticky", 32'(nextPc), 32'hA1);

    doReset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0 || (mPhase == 2 && $urandom_range(0, 9) == 0)) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                      ($urandom_range(0, 1) == 0) ? mNextPc : 8'($urandom),
                      8'($urandom), 8'($urandom));
        checkAll("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Producer side of the program-counter interface.
- Computes and registers the next instruction address that drives the pc block's NextI input.
- Consumes the pc block's current value (NextO) together with decode-stage control: sequential, branch, jump, call/return, stall, halt.
- Holds a small return-address stack and a boot/run/halt sequencer. Sits between decode control and pc in the microprocessor top level.

Parameters:
- ADDR_W, 8, address width; matches pc NextI/NextO.
- RESET_VECTOR, 8'h00, first address issued after reset.
- STACK_DEPTH, 4, return-address stack entries (power of 2, 2..8).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- pc_in  in  ADDR_W  current PC (pc NextO).
- stall  in  1  hold next_pc this cycle.
- branch_taken  in  1  conditional branch resolved taken.
- branch_off  in  ADDR_W  two's-complement branch offset.
- jump  in  1  unconditional jump.
- call  in  1  subroutine call (jump + push return address).
- ret  in  1  subroutine return (pop).
- target  in  ADDR_W  absolute target for jump/call.
- halt_req  in  1  stop fetching.
- next_pc  out  ADDR_W  registered next address (to pc NextI).
- valid  out  1  next_pc is a fetch address.
- halted  out  1  unit is in HALT.
- stk_ovf  out  1  sticky: call with full stack.
- stk_unf  out  1  sticky: ret with empty stack.

Behaviour:
- Reset (async, active-high), all outputs and state:
  - next_pc=RESET_VECTOR, valid=0, halted=0, stk_ovf=0, stk_unf=0.
  - Stack pointer=0 (empty), state=BOOT.
- FSM, BOOT -> RUN: BOOT lasts exactly one clk after reset release. next_pc stays RESET_VECTOR; valid rises to 1 on that edge.
- FSM, RUN -> HALT: taken on the edge where halt_req=1 and stall=0.
  - next_pc is frozen.
  - valid=0 and halted=1 from that edge on.
- FSM, HALT: sticky. Exits only via reset; all inputs are ignored.
- RUN update, one-cycle latency: on each rising edge with stall=0, next_pc <= f(pc_in, controls).
- RUN priority, highest first: halt_req > ret > call > jump > branch_taken > sequential.
  - ret: next_pc = top of stack; pop.
  - call: next_pc = target; push (pc_in+1).
  - jump: next_pc = target.
  - branch_taken: next_pc = pc_in + branch_off.
  - sequential: next_pc = pc_in + 1.
- Arithmetic: all address arithmetic is modulo 2^ADDR_W. 8'hFF+1 = 8'h00; 8'h02 + 8'hFC = 8'hFE.
- stall=1 in RUN:
  - next_pc, stack and flags hold; valid stays 1.
  - All controls that cycle are discarded, halt_req included.
- Return stack: LIFO. The pointer counts entries 0..STACK_DEPTH.
- Full stack on call:
  - The jump to target still happens.
  - The push is dropped; the stack is unchanged.
  - stk_ovf <= 1.
- Empty stack on ret:
  - next_pc = pc_in+1 (treated as sequential).
  - stk_unf <= 1.
- ret and call asserted together: ret wins; call is ignored, no push.
- Sticky flags clear only on reset.
- Reset mid-operation (any state): immediate async return to the reset values above. Stack contents are don't-care, but the pointer reads empty.

Decomposition:
- Shared package (microP_defs):
  - ADDR_W.
  - RESET_VECTOR.
  - FSM state encodings: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
- One sub-module: ret_stack. Parameterised LIFO with push, pop, top, full, empty; async reset of the pointer only.
- FSM, priority mux and adder stay in next_pc_unit.

Test Plan:
- Reset/boot: assert reset mid-run, release -> next_pc=8'h00, valid=0 for one edge, then valid=1. With pc_in looping from next_pc: 00,01,02,...
- Sequential wrap: pc_in=8'hFF, no controls -> next_pc=8'h00 next edge.
- Branch and jump:
  - pc_in=8'h10, branch_taken=1, branch_off=8'hFC -> next_pc=8'h0C.
  - pc_in=8'h10, jump=1, target=8'h55 -> 8'h55.
  - jump=1 and branch_taken=1 together -> jump wins (8'h55).
- Call/return nesting:
  - Call from pc_in=8'h20 and from pc_in=8'h40, target=8'h80, then two rets -> next_pc sequence 80, 80, 41, 21.
  - No flags set.
- Stack boundaries:
  - 5 calls with STACK_DEPTH=4 -> stk_ovf=1 on the 5th; 4 rets return the first four addresses in LIFO order.
  - 5th ret -> next_pc=pc_in+1, stk_unf=1.
  - Both flags stay set until reset.
- Stall/halt:
  - stall=1 with jump=1 -> next_pc unchanged, jump lost.
  - halt_req=1, stall=0 -> halted=1, valid=0, next_pc frozen; later jump/ret ignored.
  - Reset -> BOOT.
